// File: rtl/isp_delay_pkg.sv
// Shared defaults and types for the programmable pixel delay.
// Holds the buffered word layout and the fill/run state encoding.
package isp_delay_pkg;

    localparam int PKG_DATA_W        = 24;
    localparam int PKG_AW            = 6;
    localparam int PKG_DEPTH         = 1 << PKG_AW;
    localparam int PKG_DEFAULT_DELAY = 33;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } delay_state_t;

    typedef struct packed {
        logic                  vs;
        logic                  hs;
        logic                  de;
        logic [PKG_DATA_W-1:0] rgb;
    } pix_word_t;

endpackage

// File: rtl/isp_delay_ram.sv
// Simple dual-port circular buffer, one write and one registered read per cycle.
// Read-first and unreset so it maps onto LUTRAM/BRAM.
module isp_delay_ram
    import isp_delay_pkg::*;
#(
    parameter int WIDTH = PKG_DATA_W + 3,
    parameter int AW    = PKG_AW
) (
    input  logic             pixelclk,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];

    // Both accesses in one process: a same-slot read returns the old word.
    always_ff @(posedge pixelclk) begin
        r_mem[i_waddr] <= i_wdata;
        o_rdata        <= r_mem[i_raddr];
    end

endmodule

// File: rtl/isp_prog_delay.sv
// Programmable L-cycle delay of {vs, hs, de, rgb} through a circular buffer.
// L is latched on a vs rising edge; outputs are blanked while the buffer refills.
module isp_prog_delay
    import isp_delay_pkg::*;
#(
    parameter int DATA_W        = PKG_DATA_W,
    parameter int DEPTH         = PKG_DEPTH,
    parameter int AW            = PKG_AW,
    parameter int DEFAULT_DELAY = PKG_DEFAULT_DELAY
) (
    input  logic              pixelclk,
    input  logic              rst_n,
    input  logic [AW:0]       i_cfg_delay,
    input  logic [DATA_W-1:0] i_rgb,
    input  logic              i_de,
    input  logic              i_hs,
    input  logic              i_vs,
    output logic [DATA_W-1:0] o_rgb,
    output logic              o_de,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_valid,
    output logic              o_cfg_err
);

    typedef logic [AW:0]   len_t;
    typedef logic [AW-1:0] addr_t;

    localparam len_t  LEN_MIN   = len_t'(2);
    localparam len_t  LEN_MAX   = len_t'(DEPTH);
    localparam len_t  LEN_RST   = len_t'(DEFAULT_DELAY);
    localparam addr_t RADDR_RST = addr_t'(DEPTH + 1 - DEFAULT_DELAY);

    function automatic len_t f_sat_delay(input len_t req);
        if (req < LEN_MIN) return LEN_MIN;
        if (req > LEN_MAX) return LEN_MAX;
        return req;
    endfunction

    addr_t        r_wptr;
    addr_t        r_raddr_p0;
    logic         r_vs_d;
    len_t         r_len;
    len_t         w_len_nxt;
    len_t         r_fill_cnt;
    len_t         w_fill_nxt;
    delay_state_t r_state;
    delay_state_t w_state_nxt;
    logic         r_cfg_err;
    len_t         w_cfg_sat;
    logic         w_cfg_bad;
    logic         w_vs_rise;
    pix_word_t    w_wr_word_p0;
    pix_word_t    w_ram_q_p1;
    pix_word_t    r_out_p2;
    logic         r_valid_p2;

    assign w_vs_rise    = i_vs & ~r_vs_d;
    assign w_cfg_sat    = f_sat_delay(i_cfg_delay);
    assign w_cfg_bad    = (w_cfg_sat != i_cfg_delay);
    assign w_wr_word_p0 = '{vs: i_vs, hs: i_hs, de: i_de, rgb: i_rgb};

    // ---- stage p0: write pointer, read address, config latch
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_raddr_p0 <= RADDR_RST;
            r_vs_d     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_wptr     <= r_wptr + addr_t'(1);
            // Address for the next edge's read, so it uses the L taking effect now.
            r_raddr_p0 <= r_wptr - addr_t'(w_len_nxt) + addr_t'(2);
            r_vs_d     <= i_vs;
            if (w_vs_rise)
                r_cfg_err <= w_cfg_bad;
        end
    end

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_len      <= LEN_RST;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_fill_cnt <= w_fill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_fill_nxt  = r_fill_cnt;
        case (r_state)
            FILL: begin
                if (r_fill_cnt == r_len - len_t'(1))
                    w_state_nxt = RUN;
                else
                    w_fill_nxt = r_fill_cnt + len_t'(1);
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
        // Restart counts the triggering edge, matching the edge after reset release.
        if (w_vs_rise && (w_cfg_sat != r_len)) begin
            w_len_nxt   = w_cfg_sat;
            w_state_nxt = FILL;
            w_fill_nxt  = len_t'(1);
        end
    end

    // ---- stage p1: buffer read
    isp_delay_ram #(
        .WIDTH ($bits(pix_word_t)),
        .AW    (AW)
    ) u_ram (
        .pixelclk (pixelclk),
        .i_waddr  (r_wptr),
        .i_wdata  (w_wr_word_p0),
        .i_raddr  (r_raddr_p0),
        .o_rdata  (w_ram_q_p1)
    );

    // ---- stage p2: gated output register
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_p2   <= '0;
            r_valid_p2 <= 1'b0;
        end else if (r_state == RUN) begin
            r_out_p2   <= w_ram_q_p1;
            r_valid_p2 <= 1'b1;
        end else begin
            r_out_p2   <= '0;
            r_valid_p2 <= 1'b0;
        end
    end

    assign o_rgb     = r_out_p2.rgb;
    assign o_de      = r_out_p2.de;
    assign o_hs      = r_out_p2.hs;
    assign o_vs      = r_out_p2.vs;
    assign o_valid   = r_valid_p2;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_isp_prog_delay.sv
// Randomized bench for isp_prog_delay against a cycle-history reference model.
module tb_isp_prog_delay;
    import isp_delay_pkg::*;

    localparam int DEPTH = PKG_DEPTH;
    localparam int AW    = PKG_AW;
    localparam int HMAX  = 16384;

    logic              pixelclk = 1'b0;
    logic              rst_n;
    logic [AW:0]       i_cfg_delay;
    logic [PKG_DATA_W-1:0] i_rgb;
    logic              i_de, i_hs, i_vs;
    logic [PKG_DATA_W-1:0] o_rgb;
    logic              o_de, o_hs, o_vs, o_valid, o_cfg_err;

    isp_prog_delay dut (
        .pixelclk    (pixelclk),
        .rst_n       (rst_n),
        .i_cfg_delay (i_cfg_delay),
        .i_rgb       (i_rgb),
        .i_de        (i_de),
        .i_hs        (i_hs),
        .i_vs        (i_vs),
        .o_rgb       (o_rgb),
        .o_de        (o_de),
        .o_hs        (o_hs),
        .o_vs        (o_vs),
        .o_valid     (o_valid),
        .o_cfg_err   (o_cfg_err)
    );

    always #5 pixelclk = ~pixelclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: input history indexed by edge number since reset release.
    pix_word_t hist [0:HMAX-1];
    int        n;
    int        m_len;
    int        m_start;
    logic      m_err;
    logic      m_vs_d;
    logic      ramp;
    int        ramp_val;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        m_len    = PKG_DEFAULT_DELAY;
        m_start  = 0;
        m_err    = 1'b0;
        m_vs_d   = 1'b0;
    endtask

    // Called right after a falling edge; drives one cycle and checks the result.
    task automatic step(input logic vs, input int cfg);
        pix_word_t exp_w;
        logic      exp_v;
        int        cl;
        i_vs        = vs;
        i_hs        = 1'($urandom_range(0, 1));
        i_de        = 1'($urandom_range(0, 1));
        i_rgb       = ramp ? PKG_DATA_W'(ramp_val) : PKG_DATA_W'($urandom());
        i_cfg_delay = (AW+1)'(cfg);
        ramp_val++;
        @(posedge pixelclk);
        #1;
        hist[n] = '{vs: i_vs, hs: i_hs, de: i_de, rgb: i_rgb};
        exp_v = (n >= m_start + m_len);
        exp_w = exp_v ? hist[n - m_len] : '0;
        if (i_vs && !m_vs_d) begin
            cl    = (cfg < 2) ? 2 : ((cfg > DEPTH) ? DEPTH : cfg);
            m_err = (cl != cfg);
            if (cl != m_len) begin
                m_len   = cl;
                m_start = n;
            end
        end
        m_vs_d = i_vs;
        check_eq("valid", 32'(o_valid), 32'(exp_v));
        check_eq("word", 32'({o_vs, o_hs, o_de, o_rgb}), 32'(exp_w));
        check_eq("cfg_err", 32'(o_cfg_err), 32'(m_err));
        n++;
        @(negedge pixelclk);
    endtask

    // vs is high for three cycles starting at vs_at (negative: no pulse).
    task automatic run(input int cycles, input int vs_at, input int cfg);
        for (int k = 0; k < cycles; k++)
            step((vs_at >= 0) && (k >= vs_at) && (k < vs_at + 3), cfg);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_rgb"}, 32'(o_rgb), 32'd0);
        check_eq({tag, "_strb"}, 32'({o_vs, o_hs, o_de}), 32'd0);
        check_eq({tag, "_valid"}, 32'(o_valid), 32'd0);
        check_eq({tag, "_err"}, 32'(o_cfg_err), 32'd0);
    endtask

    // Asserts reset mid-cycle, checks the immediate clear, releases after a falling edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0; i_rgb = '0;
        repeat (3) @(posedge pixelclk);
        #1;
        check_zero({tag, "_held"});
        @(negedge pixelclk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cfg;
        rst_n = 1'b0;
        i_cfg_delay = '0; i_rgb = '0; i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b0;
        ramp = 1'b1; ramp_val = 0;
        model_reset();
        @(negedge pixelclk);
        @(negedge pixelclk);
        #1;
        check_zero("rst");
        @(negedge pixelclk);
        rst_n = 1'b1;

        // Ramp at the default delay.
        run(100, -1, 7);

        // Short delay, then illegal low value, then recovery.
        ramp = 1'b0;
        run(40, 4, 5);
        run(30, 4, 0);
        run(40, 4, 10);

        // Full-depth delay over several pointer wraps.
        run(300, 4, 64);

        // Mid-frame change is ignored until the next vs; repeating it does not restart.
        run(80, 4, 33);
        run(40, -1, 12);
        run(40, 4, 12);
        run(40, 4, 12);

        // Illegal high value clamps to full depth.
        run(150, 4, 120);

        // Restart during FILL with a different value.
        run(6, 1, 20);
        run(60, 1, 9);

        // Reset during FILL and during RUN.
        ramp = 1'b1;
        run(10, 2, 40);
        do_reset("rst_fill");
        run(60, -1, 40);
        do_reset("rst_run");
        run(60, -1, 40);

        // Random frames with random configuration.
        ramp = 1'b0;
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 3) == 0)
                cfg = int'($urandom_range(0, 127));
            else
                cfg = int'($urandom_range(2, DEPTH));
            run(int'($urandom_range(20, 120)), int'($urandom_range(0, 10)), cfg);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
